// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the eight-digit seven-segment scanner.
//   SEG_BLANK : all segments dark (active-low, {g,f,e,d,c,b,a})
//   AN_OFF    : all digit anodes off (active-low)
//   SEG_TABLE : hex 0..F to active-low glyph, index = nibble value
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;
  localparam int         NUM_DIGITS = 8;

  // Standard hex glyphs; lower case b and d keep them distinct from 8 and 0.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, // 0
    7'h79, // 1
    7'h24, // 2
    7'h30, // 3
    7'h19, // 4
    7'h12, // 5
    7'h02, // 6
    7'h78, // 7
    7'h00, // 8
    7'h10, // 9
    7'h08, // A
    7'h03, // b
    7'h46, // C
    7'h21, // d
    7'h06, // E
    7'h0E  // F
  };

endpackage

// File: rtl/seg7_scanner_if.sv
// -----------------------------------------------------------------------------
// seg7_scanner_if
// Bundles the scanner's display-side signals so an environment can pass them
// around as one object.
//   data[31:0] : word to show, nibble i on digit i
//   dp[7:0]    : decimal point request per digit, 1 = lit
//   en         : display enable
//   an[7:0]    : digit anodes, active-low
//   seg[6:0]   : segments {g,f,e,d,c,b,a}, active-low
//   dp_n       : decimal point segment, active-low
//   frame      : one-cycle pulse in the cycle data/dp are snapshotted
// Handshake: there is no valid/ready pair; data, dp and en are level inputs
// sampled every rising clock edge, and frame is the only event indication.
// -----------------------------------------------------------------------------
interface seg7_scanner_if;

  logic [31:0] data;
  logic [7:0]  dp;
  logic        en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame;

  // master: the side producing the display word (e.g. a testbench)
  modport master (output data, dp, en, input an, seg, dp_n, frame);
  // slave: the scanner itself
  modport slave  (input data, dp, en, output an, seg, dp_n, frame);

endinterface

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to active-low seven-segment glyph.
//   hex[3:0]   : nibble value
//   seg_n[6:0] : {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scanner.sv
// -----------------------------------------------------------------------------
// seg7_scanner
// Time-multiplexes a 32-bit word onto eight seven-segment digits.
// Each digit owns a slot of PRESCALE cycles; the first GUARD cycles of a slot
// are blanked so the previous digit's glyph does not ghost onto the next one.
// data/dp are snapshotted once per frame (end of digit 7) and only the
// snapshot is displayed, so one frame never mixes two words.
//   clk            : clock, rising edge
//   reset          : asynchronous, active-high
//   data[31:0]     : word to show, nibble i on digit i
//   dp[7:0]        : decimal point request per digit, 1 = lit
//   en             : display enable (blanks outputs only; scanning continues)
//   an[7:0]        : digit anodes, active-low
//   seg[6:0]       : segments {g,f,e,d,c,b,a}, active-low
//   dp_n           : decimal point segment, active-low
//   frame          : one-cycle pulse in the snapshot cycle
// -----------------------------------------------------------------------------
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame
);

  generate
    if (PRESCALE < 2 || GUARD < 0 || GUARD >= PRESCALE) begin : g_bad_params
      $error("seg7_scanner: illegal parameters PRESCALE=%0d GUARD=%0d", PRESCALE, GUARD);
    end
  endgenerate

  localparam int            CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0] cnt_q,         cnt_d;
  logic [2:0]    digit_q,       digit_d;
  logic [31:0]   shadow_data_q, shadow_data_d;
  logic [7:0]    shadow_dp_q,   shadow_dp_d;
  logic [7:0]    an_q,          an_d;
  logic [6:0]    seg_q,         seg_d;
  logic          dp_n_q,        dp_n_d;
  logic          frame_q,       frame_d;

  logic          wrap;
  logic          snap;
  logic          show;
  logic [3:0]    nibble_d;
  logic [6:0]    glyph_d;

  // Single decoder, fed with the nibble the next cycle will display.
  hex_to_seg7 u_dec (
    .hex   (nibble_d),
    .seg_n (glyph_d)
  );

  // Outputs are registered from next-state values, so in any cycle the
  // registered an/seg/dp_n belong to the cnt/digit held in that same cycle.
  always_comb begin
    wrap          = (cnt_q == CNT_LAST);
    snap          = wrap && (digit_q == 3'd7);

    cnt_d         = wrap ? '0 : cnt_q + CW'(1);
    digit_d       = wrap ? digit_q + 3'd1 : digit_q;

    shadow_data_d = snap ? data : shadow_data_q;
    shadow_dp_d   = snap ? dp   : shadow_dp_q;

    // frame marks the snapshot cycle itself, i.e. the last cycle of digit 7.
    frame_d       = (cnt_d == CNT_LAST) && (digit_d == 3'd7);

    nibble_d      = 4'(shadow_data_d >> {digit_d, 2'b00});

    // en is sampled live: raising it mid-slot shows the digit next cycle.
    show          = en && (cnt_d >= GUARD_C);

    an_d          = AN_OFF;
    seg_d         = SEG_BLANK;
    dp_n_d        = 1'b1;
    if (show) begin
      an_d   = ~(8'd1 << digit_d);
      seg_d  = glyph_d;
      dp_n_d = ~shadow_dp_d[digit_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      digit_q       <= 3'd0;
      shadow_data_q <= 32'd0;
      shadow_dp_q   <= 8'd0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      dp_n_q        <= 1'b1;
      frame_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      frame_q       <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp_n  = dp_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg7_scanner
// Directed bench for seg7_scanner with PRESCALE=8, GUARD=2.
// Cycle numbering: cycle 0 is the first cycle after reset release
// (cnt = cyc % 8, digit = (cyc / 8) % 8, frame k spans cycles 64k..64k+63).
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_seg7_scanner;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  seg7_scanner_if sif ();

  seg7_scanner #(
    .PRESCALE (8),
    .GUARD    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .data  (sif.data),
    .dp    (sif.dp),
    .en    (sif.en),
    .an    (sif.an),
    .seg   (sif.seg),
    .dp_n  (sif.dp_n),
    .frame (sif.frame)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_an,
                         input logic [6:0] e_seg, input logic e_dpn);
    chk({tag, ".an"},   32'(sif.an),   32'(e_an));
    chk({tag, ".seg"},  32'(sif.seg),  32'(e_seg));
    chk({tag, ".dp_n"}, 32'(sif.dp_n), 32'(e_dpn));
  endtask

  task automatic chk_reset_state(input string tag);
    chk_out(tag, 8'hFF, 7'h7F, 1'b1);
    chk({tag, ".frame"},  32'(sif.frame),          32'd0);
    chk({tag, ".cnt"},    32'(dut.cnt_q),          32'd0);
    chk({tag, ".digit"},  32'(dut.digit_q),        32'd0);
    chk({tag, ".sdata"},  dut.shadow_data_q,       32'd0);
    chk({tag, ".sdp"},    32'(dut.shadow_dp_q),    32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    reset     = 1'b1;
    sif.en    = 1'b1;
    sif.data  = 32'd0;
    sif.dp    = 8'd0;

    // ---- reset state, then release: scenario 1 ----
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_state("rst0");
    reset = 1'b0;
    cyc   = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      if (c < 2)      chk_out("s1_guard", 8'hFF, 7'h7F, 1'b1);
      else if (c < 8) chk_out("s1_show",  8'hFE, 7'h40, 1'b1);
      else            chk_out("s1_d1",    8'hFF, 7'h7F, 1'b1);
    end
    chk("s1_cnt8",   32'(dut.cnt_q),   32'd0);
    chk("s1_digit8", 32'(dut.digit_q), 32'd1);

    // ---- scenario 2: new word, visible only from frame 1 ----
    sif.data = 32'h0123_89AF;
    run_to(62);
    chk("s2_frame62", 32'(sif.frame), 32'd0);
    tick();
    chk("s2_frame63", 32'(sif.frame), 32'd1);
    chk_out("s2_c63", 8'h7F, 7'h40, 1'b1);
    tick();
    chk("s2_frame64", 32'(sif.frame), 32'd0);
    chk_out("s2_c64", 8'hFF, 7'h7F, 1'b1);
    run_to(66);
    chk_out("s2_d0", 8'hFE, 7'h0E, 1'b1);
    run_to(74);
    chk_out("s2_d1", 8'hFD, 7'h08, 1'b1);

    // ---- scenario 3: mid-frame data change ----
    run_to(80);
    sif.data = 32'hFFFF_FFFF;
    run_to(82);
    chk_out("s3_d2", 8'hFB, 7'h10, 1'b1);
    run_to(99);
    chk_out("s3_d4", 8'hEF, 7'h30, 1'b1);
    run_to(122);
    chk_out("s3_d7", 8'h7F, 7'h40, 1'b1);
    for (int k = 0; k < 8; k++) begin
      run_to(128 + 8 * k + 2);
      chk_out("s3_f2", ~(8'd1 << k), 7'h0E, 1'b1);
      if (k == 0) sif.dp = 8'h80;
    end

    // ---- scenario 4: decimal point on digit 7 from frame 3 ----
    run_to(242);
    chk_out("s4_d6", 8'hBF, 7'h0E, 1'b1);
    run_to(248);
    chk_out("s4_g0", 8'hFF, 7'h7F, 1'b1);
    tick();
    chk_out("s4_g1", 8'hFF, 7'h7F, 1'b1);
    tick();
    chk_out("s4_s2", 8'h7F, 7'h0E, 1'b0);
    run_to(255);
    chk_out("s4_s7", 8'h7F, 7'h0E, 1'b0);
    chk("s4_frame", 32'(sif.frame), 32'd1);

    // ---- scenario 5: display disabled for 20 cycles ----
    run_to(305);
    sif.en = 1'b0;
    for (int c = 306; c <= 325; c++) begin
      run_to(c);
      chk("s5_blank", 32'(sif.an), 32'hFF);
      if (c == 318) chk("s5_frame318", 32'(sif.frame), 32'd0);
      if (c == 319) chk("s5_frame319", 32'(sif.frame), 32'd1);
    end
    chk("s5_cnt", 32'(dut.cnt_q), 32'd5);
    sif.en = 1'b1;
    tick();
    chk_out("s5_resume", 8'hFE, 7'h0E, 1'b1);

    // ---- scenario 6: reset at digit 4, cnt 6 ----
    run_to(422);
    chk_out("s6_pre", 8'hEF, 7'h0E, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk_reset_state("s6_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    chk_out("s6_c0", 8'hFF, 7'h7F, 1'b1);
    run_to(2);
    chk_out("s6_c2", 8'hFE, 7'h40, 1'b1);
    run_to(58);
    chk_out("s6_d7", 8'h7F, 7'h40, 1'b1);
    run_to(63);
    chk("s6_frame", 32'(sif.frame), 32'd1);
    run_to(66);
    chk_out("s6_f1d0", 8'hFE, 7'h0E, 1'b1);
    run_to(122);
    chk_out("s6_f1d7", 8'h7F, 7'h0E, 1'b0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
